reg_file: RTL and testbench
===========================

# reg_file

Parametrised, clocked general-purpose register file for the CPU datapath, replacing the combinational load-only register bank. It holds NUM_REGS registers of DATA_W bits and provides two asynchronous read ports, an ALU write port and a memory-load write port. A per-register load scoreboard (busy bits) lets the decode stage stall on registers whose load data has not yet returned. Optional write-to-read bypass is provided.

## Interface
- DATA_W, 32, register width in bits
- NUM_REGS, 16, number of registers; 2 ≤ NUM_REGS ≤ 2^ADDR_W
- ADDR_W, 4, register address width
- BYPASS, 1, 1 = same-cycle write data and busy-clear forwarded to read ports; 0 = reads show registered state only
- clk  in  1  clock, all state updates on rising edge
- reset_n  in  1  reset, asynchronous, active-low
- rd_addr_a / rd_addr_b  in  ADDR_W  read port A/B register address
- rd_data_a / rd_data_b  out  DATA_W  read data, combinational
- rd_busy_a / rd_busy_b  out  1  addressed register has a load outstanding
- alu_we  in  1  ALU write strobe
- alu_waddr  in  ADDR_W  ALU destination register
- alu_wdata  in  DATA_W  ALU result
- ld_issue  in  1  load issued; sets busy bit of ld_issue_addr
- ld_issue_addr  in  ADDR_W  load destination register
- ld_issue_ready  out  1  ld_issue_addr not busy (issue may be accepted)
- ld_valid  in  1  load data return strobe
- ld_waddr  in  ADDR_W  returning load destination register
- ld_wdata  in  DATA_W  returning load data
- busy_mask  out  NUM_REGS  registered busy bits, bit i = register i
- wr_err  out  1  one-cycle pulse on protocol violation (registered)

## Operation
- Storage: NUM_REGS × DATA_W flops; reset clears all to 0, busy_mask to 0, wr_err to 0.
- Load write: ld_valid and ld_waddr < NUM_REGS → reg[ld_waddr] ← ld_wdata, busy[ld_waddr] ← 0.
- ALU write: alu_we and alu_waddr < NUM_REGS and busy[alu_waddr] = 0 → reg[alu_waddr] ← alu_wdata.
- ALU write to a busy register: write dropped, wr_err pulses.
- ld_valid to a non-busy register: data still written, wr_err pulses.
- alu_we and ld_valid to the same address same cycle: load data wins, ALU data dropped, wr_err pulses.
- Load issue: ld_issue and ld_issue_addr < NUM_REGS and ld_issue_ready → busy[ld_issue_addr] ← 1. ld_issue while ld_issue_ready = 0: ignored, wr_err pulses.
- ld_issue_ready = ~busy[ld_issue_addr], or 1 if the same-cycle ld_valid returns to that address (issue and return same register same cycle: data written, busy ends 1).
- Addresses ≥ NUM_REGS: writes and issues ignored (no wr_err); reads return 0, busy 0.
- Reads: rd_data_x = reg[rd_addr_x]. With BYPASS=1, priority: ld_valid match → ld_wdata; accepted ALU write match → alu_wdata; else stored value. rd_busy_x = busy[rd_addr_x], forced 0 when BYPASS=1 and ld_valid returns to that address this cycle.
- Multiple wr_err causes in one cycle produce a single pulse.

## Timing
- Write latency: 1 cycle (visible in storage next cycle; same cycle via bypass when BYPASS=1).
- Busy set visible on busy_mask/rd_busy the cycle after ld_issue; clear visible next cycle (same cycle via bypass).
- wr_err asserted the cycle after the offending edge, for exactly one cycle.
- reset_n low at any time: immediate clear of all state; outstanding loads forgotten; ld_valid arriving after reset release to a non-busy register writes and pulses wr_err.
- No combinational path from ld_issue to ld_issue_ready.

## Test plan
- Reset: hold reset_n low mid-traffic → all rd_data 0, busy_mask 0, wr_err 0 immediately.
- ALU write alu_waddr=3, data 0xDEADBEEF; rd_addr_a=3 same cycle → BYPASS=1 shows 0xDEADBEEF same cycle, BYPASS=0 next cycle.
- ld_issue to r5 → busy_mask=0x0020 next cycle, rd_busy_a=1 for r5, ld_issue_ready=0; ld_valid r5 data 0x12345678 → rd_busy 0 and data forwarded that cycle, busy_mask=0 after.
- ALU write to busy r5 → r5 unchanged, wr_err single pulse; same-cycle alu_we and ld_valid to r7 → r7=ld_wdata, wr_err pulse.
- Same-cycle ld_valid and ld_issue on r2 → r2 updated, busy[2] stays 1; second ld_issue to busy r2 → ignored, wr_err pulse.
- NUM_REGS=12, write/read address 13 → no state change, read 0, no wr_err.

Source files
------------

// File: rtl/reg_file_if.sv
// Register-file port bundle: two read ports, ALU and load write ports, load-scoreboard status.
// The master side is the datapath/decode stage; the slave side is the register file.
interface reg_file_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4
);
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_a;
  logic [DATA_W-1:0]   rd_data_b;
  logic                rd_busy_a;
  logic                rd_busy_b;
  logic                alu_we;
  logic [ADDR_W-1:0]   alu_waddr;
  logic [DATA_W-1:0]   alu_wdata;
  logic                ld_issue;
  logic [ADDR_W-1:0]   ld_issue_addr;
  logic                ld_issue_ready;
  logic                ld_valid;
  logic [ADDR_W-1:0]   ld_waddr;
  logic [DATA_W-1:0]   ld_wdata;
  logic [NUM_REGS-1:0] busy_mask;
  logic                wr_err;

  modport master (
    output rd_addr_a, rd_addr_b, alu_we, alu_waddr, alu_wdata,
           ld_issue, ld_issue_addr, ld_valid, ld_waddr, ld_wdata,
    input  rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, ld_issue_ready, busy_mask, wr_err
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, alu_we, alu_waddr, alu_wdata,
           ld_issue, ld_issue_addr, ld_valid, ld_waddr, ld_wdata,
    output rd_data_a, rd_data_b, rd_busy_a, rd_busy_b, ld_issue_ready, busy_mask, wr_err
  );
endinterface

// File: rtl/reg_file.sv
// Register file with load scoreboard: writes land next cycle (reads see them same cycle when BYPASS=1).
// No backpressure: ld_issue_ready only advises; rejected writes/issues raise a registered wr_err pulse.
module reg_file #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 4,
  parameter int BYPASS   = 1
) (
  input logic       clk,
  input logic       reset_n,
  reg_file_if.slave bus
);

  localparam logic [ADDR_W:0] NREG = (ADDR_W+1)'(NUM_REGS);

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return {1'b0, a} < NREG;
  endfunction

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] busy_q;
  logic                wr_err_q;

  function automatic logic busy_of(input logic [NUM_REGS-1:0] b, input logic [ADDR_W-1:0] a);
    return in_range(a) ? b[a] : 1'b0;
  endfunction

  logic ld_hit, alu_hit, iss_hit, alu_same, alu_ok, iss_ready, err_d;

  assign ld_hit   = bus.ld_valid & in_range(bus.ld_waddr);
  assign alu_hit  = bus.alu_we & in_range(bus.alu_waddr);
  assign iss_hit  = bus.ld_issue & in_range(bus.ld_issue_addr);
  assign alu_same = ld_hit & (bus.ld_waddr == bus.alu_waddr);
  assign alu_ok   = alu_hit & ~busy_of(busy_q, bus.alu_waddr) & ~alu_same;
  // A load returning to the issue target frees it this cycle; depends only on registered busy and ld_*.
  assign iss_ready = ~busy_of(busy_q, bus.ld_issue_addr)
                   | (ld_hit & (bus.ld_waddr == bus.ld_issue_addr));
  assign err_d = (alu_hit & ~alu_ok)
               | (ld_hit & ~busy_of(busy_q, bus.ld_waddr))
               | (iss_hit & ~iss_ready);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      busy_q   <= '0;
      wr_err_q <= 1'b0;
    end else begin
      wr_err_q <= err_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        if (ld_hit && bus.ld_waddr == ADDR_W'(i))
          regs_q[i] <= bus.ld_wdata;
        else if (alu_ok && bus.alu_waddr == ADDR_W'(i))
          regs_q[i] <= bus.alu_wdata;
        // Issue after return on the same register leaves it busy for the new load.
        if (iss_hit && iss_ready && bus.ld_issue_addr == ADDR_W'(i))
          busy_q[i] <= 1'b1;
        else if (ld_hit && bus.ld_waddr == ADDR_W'(i))
          busy_q[i] <= 1'b0;
      end
    end
  end

  logic [ADDR_W-1:0] ra [2];
  logic [DATA_W-1:0] rd [2];
  logic              rb [2];

  assign ra[0] = bus.rd_addr_a;
  assign ra[1] = bus.rd_addr_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rd[p] = '0;
      rb[p] = 1'b0;
      if (in_range(ra[p])) begin
        rd[p] = regs_q[ra[p]];
        rb[p] = busy_q[ra[p]];
        if (BYPASS != 0 && ld_hit && bus.ld_waddr == ra[p]) begin
          rd[p] = bus.ld_wdata;
          rb[p] = 1'b0;
        end else if (BYPASS != 0 && alu_ok && bus.alu_waddr == ra[p]) begin
          rd[p] = bus.alu_wdata;
        end
      end
    end
  end

  assign bus.rd_data_a      = rd[0];
  assign bus.rd_data_b      = rd[1];
  assign bus.rd_busy_a      = rb[0];
  assign bus.rd_busy_b      = rb[1];
  assign bus.ld_issue_ready = iss_ready;
  assign bus.busy_mask      = busy_q;
  assign bus.wr_err         = wr_err_q;

endmodule

// File: tb/tb_reg_file.sv
// Bench for reg_file: directed vector table, hand sequences and random traffic on two configurations
// (16 regs with bypass, 12 regs without), both compared to a register/scoreboard array model.
module tb_reg_file;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  reg_file_if #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4)) ifa ();
  reg_file_if #(.DATA_W(32), .NUM_REGS(12), .ADDR_W(4)) ifb ();

  reg_file #(.DATA_W(32), .NUM_REGS(16), .ADDR_W(4), .BYPASS(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa));
  reg_file #(.DATA_W(32), .NUM_REGS(12), .ADDR_W(4), .BYPASS(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb));

  typedef struct {
    logic        alu_we;
    logic [3:0]  alu_waddr;
    logic [31:0] alu_wdata;
    logic        ld_issue;
    logic [3:0]  ld_issue_addr;
    logic        ld_valid;
    logic [3:0]  ld_waddr;
    logic [31:0] ld_wdata;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
  } stim_t;

  typedef struct {
    stim_t       s;
    logic [31:0] e_data;
    logic        e_busy;
    logic        e_rdy;
    logic [15:0] e_mask;
    logic        e_err;
  } vec_t;

  int checks = 0;
  int errors = 0;
  stim_t cur;
  stim_t idle;
  vec_t  tbl [20];

  logic [31:0] m_reg  [2][16];
  logic        m_busy [2][16];
  logic        m_err  [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t mk_s(input logic we, input logic [3:0] aa, input logic [31:0] ad,
                                 input logic iss, input logic [3:0] ia, input logic lv,
                                 input logic [3:0] la, input logic [31:0] ld, input logic [3:0] ra);
    stim_t s;
    s.alu_we = we;  s.alu_waddr = aa;     s.alu_wdata = ad;
    s.ld_issue = iss; s.ld_issue_addr = ia;
    s.ld_valid = lv; s.ld_waddr = la;     s.ld_wdata = ld;
    s.rd_addr_a = ra; s.rd_addr_b = 4'(ra + 4'd1);
    return s;
  endfunction

  function automatic vec_t mk_v(input stim_t s, input logic [31:0] d, input logic b,
                                input logic r, input logic [15:0] m, input logic e);
    vec_t v;
    v.s = s; v.e_data = d; v.e_busy = b; v.e_rdy = r; v.e_mask = m; v.e_err = e;
    return v;
  endfunction

  task automatic set_inputs(input stim_t s);
    cur = s;
    ifa.alu_we = s.alu_we;     ifa.alu_waddr = s.alu_waddr;         ifa.alu_wdata = s.alu_wdata;
    ifa.ld_issue = s.ld_issue; ifa.ld_issue_addr = s.ld_issue_addr;
    ifa.ld_valid = s.ld_valid; ifa.ld_waddr = s.ld_waddr;           ifa.ld_wdata = s.ld_wdata;
    ifa.rd_addr_a = s.rd_addr_a; ifa.rd_addr_b = s.rd_addr_b;
    ifb.alu_we = s.alu_we;     ifb.alu_waddr = s.alu_waddr;         ifb.alu_wdata = s.alu_wdata;
    ifb.ld_issue = s.ld_issue; ifb.ld_issue_addr = s.ld_issue_addr;
    ifb.ld_valid = s.ld_valid; ifb.ld_waddr = s.ld_waddr;           ifb.ld_wdata = s.ld_wdata;
    ifb.rd_addr_a = s.rd_addr_a; ifb.rd_addr_b = s.rd_addr_b;
  endtask

  // Reference model: configuration 0 has 16 regs with forwarding, configuration 1 has 12 without.
  function automatic int nr(input int k);
    return (k == 0) ? 16 : 12;
  endfunction

  function automatic logic inr(input int k, input logic [3:0] a);
    return int'(a) < nr(k);
  endfunction

  function automatic logic m_ldok(input int k);
    return cur.ld_valid && inr(k, cur.ld_waddr);
  endfunction

  function automatic logic m_alu_acc(input int k);
    return cur.alu_we && inr(k, cur.alu_waddr) && !m_busy[k][cur.alu_waddr]
           && !(m_ldok(k) && cur.ld_waddr == cur.alu_waddr);
  endfunction

  function automatic logic [31:0] m_data(input int k, input logic [3:0] a);
    if (!inr(k, a)) return 32'h0;
    if (k == 0 && m_ldok(k) && a == cur.ld_waddr) return cur.ld_wdata;
    if (k == 0 && m_alu_acc(k) && a == cur.alu_waddr) return cur.alu_wdata;
    return m_reg[k][a];
  endfunction

  function automatic logic m_rbusy(input int k, input logic [3:0] a);
    if (!inr(k, a)) return 1'b0;
    if (k == 0 && m_ldok(k) && a == cur.ld_waddr) return 1'b0;
    return m_busy[k][a];
  endfunction

  function automatic logic m_ready(input int k);
    logic b;
    b = inr(k, cur.ld_issue_addr) && m_busy[k][cur.ld_issue_addr];
    return !b || (m_ldok(k) && cur.ld_waddr == cur.ld_issue_addr);
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < 16; i++) begin
        m_reg[k][i] = 32'h0;
        m_busy[k][i] = 1'b0;
      end
      m_err[k] = 1'b0;
    end
  endtask

  task automatic model_update();
    logic ldok, alu_in, iss_in, rdy, acc, e;
    for (int k = 0; k < 2; k++) begin
      ldok   = m_ldok(k);
      alu_in = cur.alu_we && inr(k, cur.alu_waddr);
      iss_in = cur.ld_issue && inr(k, cur.ld_issue_addr);
      rdy    = m_ready(k);
      acc    = m_alu_acc(k);
      e = (alu_in && !acc) || (ldok && !m_busy[k][cur.ld_waddr]) || (iss_in && !rdy);
      if (acc) m_reg[k][cur.alu_waddr] = cur.alu_wdata;
      if (ldok) begin
        m_reg[k][cur.ld_waddr]  = cur.ld_wdata;
        m_busy[k][cur.ld_waddr] = 1'b0;
      end
      if (iss_in && rdy) m_busy[k][cur.ld_issue_addr] = 1'b1;
      m_err[k] = e;
    end
  endtask

  task automatic get_out(input int k, output logic [31:0] da, output logic [31:0] db,
                         output logic ba, output logic bb, output logic rdy,
                         output logic [15:0] mask, output logic err);
    if (k == 0) begin
      da = ifa.rd_data_a; db = ifa.rd_data_b; ba = ifa.rd_busy_a; bb = ifa.rd_busy_b;
      rdy = ifa.ld_issue_ready; mask = ifa.busy_mask; err = ifa.wr_err;
    end else begin
      da = ifb.rd_data_a; db = ifb.rd_data_b; ba = ifb.rd_busy_a; bb = ifb.rd_busy_b;
      rdy = ifb.ld_issue_ready; mask = {4'h0, ifb.busy_mask}; err = ifb.wr_err;
    end
  endtask

  task automatic check_model();
    logic [31:0] da, db;
    logic ba, bb, rdy, err;
    logic [15:0] mask, mm;
    for (int k = 0; k < 2; k++) begin
      get_out(k, da, db, ba, bb, rdy, mask, err);
      mm = '0;
      for (int i = 0; i < 16; i++) mm[i] = m_busy[k][i];
      chk($sformatf("cfg%0d rd_data_a", k), da, m_data(k, cur.rd_addr_a));
      chk($sformatf("cfg%0d rd_data_b", k), db, m_data(k, cur.rd_addr_b));
      chk($sformatf("cfg%0d rd_busy_a", k), 32'(ba), 32'(m_rbusy(k, cur.rd_addr_a)));
      chk($sformatf("cfg%0d rd_busy_b", k), 32'(bb), 32'(m_rbusy(k, cur.rd_addr_b)));
      chk($sformatf("cfg%0d ld_issue_ready", k), 32'(rdy), 32'(m_ready(k)));
      chk($sformatf("cfg%0d busy_mask", k), 32'(mask), 32'(mm));
      chk($sformatf("cfg%0d wr_err", k), 32'(err), 32'(m_err[k]));
    end
  endtask

  task automatic begin_cycle(input stim_t s);
    @(negedge clk);
    set_inputs(s);
    #1;
    check_model();
  endtask

  task automatic end_cycle();
    @(posedge clk);
    model_update();
  endtask

  // Reset asserted mid-cycle with a load issue in flight; all outputs must clear at once.
  task automatic do_reset();
    begin_cycle(mk_s(0, 0, 0, 1, 4'd6, 0, 0, 0, 4'd3));
    #2 reset_n = 1'b0;
    #1;
    chk("reset rd_data_a", ifa.rd_data_a, 32'h0);
    chk("reset rd_data_b", ifa.rd_data_b, 32'h0);
    chk("reset busy_mask", 32'(ifa.busy_mask), 32'h0);
    chk("reset wr_err", 32'(ifa.wr_err), 32'h0);
    chk("reset cfg1 rd_data_a", ifb.rd_data_a, 32'h0);
    chk("reset cfg1 busy_mask", 32'(ifb.busy_mask), 32'h0);
    set_inputs(idle);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic stim_t rnd();
    stim_t s;
    int q[$];
    s.alu_we        = ($urandom_range(0, 1) == 1);
    s.alu_waddr     = 4'($urandom_range(0, 15));
    s.alu_wdata     = $urandom;
    s.ld_issue      = ($urandom_range(0, 9) < 4);
    s.ld_issue_addr = 4'($urandom_range(0, 15));
    s.ld_valid      = ($urandom_range(0, 9) < 4);
    s.ld_waddr      = 4'($urandom_range(0, 15));
    s.ld_wdata      = $urandom;
    for (int i = 0; i < 16; i++) if (m_busy[0][i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 3) != 0)
      s.ld_waddr = 4'(q[$urandom_range(0, q.size() - 1)]);
    case ($urandom_range(0, 3))
      0:       s.rd_addr_a = s.alu_waddr;
      1:       s.rd_addr_a = s.ld_waddr;
      default: s.rd_addr_a = 4'($urandom_range(0, 15));
    endcase
    s.rd_addr_b = ($urandom_range(0, 1) == 1) ? s.ld_waddr : 4'($urandom_range(0, 15));
    return s;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    idle = mk_s(0, 0, 0, 0, 0, 0, 0, 0, 0);
    //           we aa  ad            iss ia  lv la  ld            ra     data          b  r  mask     e
    tbl[0]  = mk_v(mk_s(1, 3, 32'hDEADBEEF, 0, 0, 0, 0, 0, 3),             32'hDEADBEEF, 0, 1, 16'h0,  0);
    tbl[1]  = mk_v(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 3),                        32'hDEADBEEF, 0, 1, 16'h0,  0);
    tbl[2]  = mk_v(mk_s(0, 0, 0, 1, 5, 0, 0, 0, 5),                        32'h0,        0, 1, 16'h0,  0);
    tbl[3]  = mk_v(mk_s(0, 0, 0, 0, 5, 0, 0, 0, 5),                        32'h0,        1, 0, 16'h20, 0);
    tbl[4]  = mk_v(mk_s(1, 5, 32'h1111, 0, 5, 0, 0, 0, 5),                 32'h0,        1, 0, 16'h20, 0);
    tbl[5]  = mk_v(mk_s(0, 0, 0, 0, 5, 1, 5, 32'h12345678, 5),             32'h12345678, 0, 1, 16'h20, 1);
    tbl[6]  = mk_v(mk_s(0, 0, 0, 0, 5, 0, 0, 0, 5),                        32'h12345678, 0, 1, 16'h0,  0);
    tbl[7]  = mk_v(mk_s(0, 0, 0, 1, 7, 0, 0, 0, 7),                        32'h0,        0, 1, 16'h0,  0);
    tbl[8]  = mk_v(mk_s(1, 7, 32'hAAAA, 0, 7, 1, 7, 32'h7777, 7),          32'h7777,     0, 1, 16'h80, 0);
    tbl[9]  = mk_v(mk_s(0, 0, 0, 0, 7, 0, 0, 0, 7),                        32'h7777,     0, 1, 16'h0,  1);
    tbl[10] = mk_v(mk_s(0, 0, 0, 1, 2, 0, 0, 0, 2),                        32'h0,        0, 1, 16'h0,  0);
    tbl[11] = mk_v(mk_s(0, 0, 0, 1, 2, 1, 2, 32'hABCD, 2),                 32'hABCD,     0, 1, 16'h4,  0);
    tbl[12] = mk_v(mk_s(0, 0, 0, 1, 2, 0, 0, 0, 2),                        32'hABCD,     1, 0, 16'h4,  0);
    tbl[13] = mk_v(mk_s(0, 0, 0, 0, 2, 0, 0, 0, 2),                        32'hABCD,     1, 0, 16'h4,  1);
    tbl[14] = mk_v(mk_s(0, 0, 0, 0, 2, 0, 0, 0, 2),                        32'hABCD,     1, 0, 16'h4,  0);
    tbl[15] = mk_v(mk_s(0, 0, 0, 0, 9, 1, 9, 32'h99, 9),                   32'h99,       0, 1, 16'h4,  0);
    tbl[16] = mk_v(mk_s(0, 0, 0, 0, 9, 0, 0, 0, 9),                        32'h99,       0, 1, 16'h4,  1);
    tbl[17] = mk_v(mk_s(1, 2, 32'h5555, 0, 2, 1, 10, 32'hAA, 2),           32'hABCD,     1, 0, 16'h4,  0);
    tbl[18] = mk_v(mk_s(0, 0, 0, 0, 2, 0, 0, 0, 2),                        32'hABCD,     1, 0, 16'h4,  1);
    tbl[19] = mk_v(mk_s(0, 0, 0, 0, 2, 0, 0, 0, 2),                        32'hABCD,     1, 0, 16'h4,  0);

    reset_n = 1'b1;
    set_inputs(idle);
    model_reset();
    #2 reset_n = 1'b0;
    #1;
    check_model();
    chk("por busy_mask", 32'(ifa.busy_mask), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      begin_cycle(tbl[i].s);
      chk($sformatf("row%0d rd_data_a", i), ifa.rd_data_a, tbl[i].e_data);
      chk($sformatf("row%0d rd_busy_a", i), 32'(ifa.rd_busy_a), 32'(tbl[i].e_busy));
      chk($sformatf("row%0d ld_issue_ready", i), 32'(ifa.ld_issue_ready), 32'(tbl[i].e_rdy));
      chk($sformatf("row%0d busy_mask", i), 32'(ifa.busy_mask), 32'(tbl[i].e_mask));
      chk($sformatf("row%0d wr_err", i), 32'(ifa.wr_err), 32'(tbl[i].e_err));
      end_cycle();
    end

    // Registered-only reads on the non-bypass configuration.
    begin_cycle(mk_s(1, 3, 32'hCAFEF00D, 0, 0, 0, 0, 0, 3));
    chk("nobyp same-cycle rd_data_a", ifb.rd_data_a, 32'hDEADBEEF);
    chk("byp same-cycle rd_data_a", ifa.rd_data_a, 32'hCAFEF00D);
    end_cycle();
    begin_cycle(mk_s(0, 0, 0, 0, 0, 0, 0, 0, 3));
    chk("nobyp next-cycle rd_data_a", ifb.rd_data_a, 32'hCAFEF00D);
    end_cycle();

    // Address 13 is beyond the 12-register configuration: all traffic ignored there.
    begin_cycle(mk_s(1, 13, 32'h13, 1, 13, 1, 13, 32'h31, 13));
    chk("oor rd_data_a", ifb.rd_data_a, 32'h0);
    chk("oor rd_busy_a", 32'(ifb.rd_busy_a), 32'h0);
    chk("oor ld_issue_ready", 32'(ifb.ld_issue_ready), 32'h1);
    end_cycle();
    begin_cycle(mk_s(0, 0, 0, 0, 13, 0, 0, 0, 13));
    chk("oor wr_err", 32'(ifb.wr_err), 32'h0);
    chk("oor busy_mask", 32'(ifb.busy_mask), 32'h4);
    chk("oor rd_data_a after", ifb.rd_data_a, 32'h0);
    chk("r13 collision wr_err", 32'(ifa.wr_err), 32'h1);
    end_cycle();

    // Outstanding load on r4 is forgotten by reset; its late return writes and flags an error.
    begin_cycle(mk_s(0, 0, 0, 1, 4, 0, 0, 0, 4));
    end_cycle();
    do_reset();
    begin_cycle(mk_s(0, 0, 0, 0, 4, 1, 4, 32'h44, 4));
    chk("post-reset ld rd_data_a", ifa.rd_data_a, 32'h44);
    end_cycle();
    begin_cycle(mk_s(0, 0, 0, 0, 4, 0, 0, 0, 4));
    chk("post-reset ld wr_err", 32'(ifa.wr_err), 32'h1);
    chk("post-reset ld cfg1 wr_err", 32'(ifb.wr_err), 32'h1);
    chk("post-reset ld cfg1 rd_data_a", ifb.rd_data_a, 32'h44);
    end_cycle();

    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      begin_cycle(rnd());
      end_cycle();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
